ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader.sv | 137 +++++++++++++
 tb/tb_ccff_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// ccff_loader -- programs a configuration flip-flop chain from a word stream.
//
// Each word is shifted into the chain head MSB first. A pass is exactly
// chain_len shifts. Bits of the final word beyond chain_len are dropped.
// When verify is requested, the host sends the same bitstream a second
// time. During that second pass every bit returned at the chain tail is
// compared with the bit being driven into the head.
//
// Ports
//   prog_clk    : clock; all state changes on its rising edge
//   pReset      : asynchronous reset, active low
//   start       : one-cycle request to begin; only honoured in IDLE
//   chain_len   : number of chain bits, sampled when start is accepted
//   verify_en   : request a verify pass, sampled when start is accepted
//   data_in     : bitstream word
//   data_valid  : data_in is valid
//   data_ready  : word is taken when data_valid && data_ready
//   ccff_head   : serial bit driven into the chain head
//   ccff_tail   : serial bit returned from the chain tail
//   shift_en    : the chain advances on every clock edge where this is 1
//   busy        : a LOAD or VERIFY pass is running
//   done        : one-cycle pulse when the sequence is finished
//   error       : at least one verify mismatch was seen
//   err_count   : number of verify mismatches, saturating at all-ones
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | shifting the bitstream into the chain
// VERIFY | shifting the bitstream again and comparing it with the tail
// FINISH | done pulse, then back to IDLE
module ccff_loader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic              verify_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  err_count
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic              verify_q;
  logic [LEN_W-1:0]  rem;        // shifts still owed in the current pass
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  bcnt;       // bits currently held in sreg
  logic [LEN_W-1:0]  bcnt_ext;
  logic              accept;
  logic              pass_end;
  logic              mismatch;

  assign bcnt_ext = LEN_W'(bcnt);
  assign busy     = (state == S_LOAD) || (state == S_VERIFY);
  assign done     = (state == S_FINISH);
  assign shift_en = busy && (bcnt != '0);
  assign ccff_head = shift_en & sreg[DATA_W-1];

  // A new word may arrive while the last buffered bit is shifting out.
  // This keeps the stream free of bubbles. No word is requested once the
  // buffered bits already cover the rest of the pass.
  assign data_ready = busy && (bcnt <= CNT_W'(1)) && (rem > bcnt_ext);
  assign accept     = data_valid && data_ready;
  assign pass_end   = shift_en && (rem == LEN_W'(1));
  assign mismatch   = (state == S_VERIFY) && shift_en && (ccff_tail != ccff_head);

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      verify_q  <= 1'b0;
      rem       <= '0;
      sreg      <= '0;
      bcnt      <= '0;
      error     <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= chain_len;
            verify_q  <= verify_en;
            rem       <= chain_len;
            error     <= 1'b0;
            err_count <= '0;
            state     <= (chain_len == '0) ? S_FINISH : S_LOAD;
          end
        end
        S_LOAD, S_VERIFY: begin
          if (shift_en)
            rem <= rem - LEN_W'(1);
          if (pass_end) begin
            // Drop any leftover bits of the final word.
            sreg <= '0;
            bcnt <= '0;
            if ((state == S_LOAD) && verify_q) begin
              state <= S_VERIFY;
              rem   <= len_q;
            end else begin
              state <= S_FINISH;
            end
          end else if (accept) begin
            sreg <= data_in;
            bcnt <= CNT_W'(DATA_W);
          end else if (shift_en) begin
            sreg <= {sreg[DATA_W-2:0], 1'b0};
            bcnt <= bcnt - CNT_W'(1);
          end
          if (mismatch) begin
            error <= 1'b1;
            if (err_count != '1)
              err_count <= err_count + LEN_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Testbench for ccff_loader.
// The chain is modelled as an 8-bit shift register, so it loops the
// loaded bitstream back to ccff_tail. Every accepted word pushes its
// expected head bits into a scoreboard queue. Each shift pops one bit
// and compares it with ccff_head.
module tb_ccff_loader;

  logic        prog_clk = 1'b0;
  logic        pReset;
  logic        start;
  logic [15:0] chain_len;
  logic        verify_en;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        ccff_head;
  logic        ccff_tail;
  logic        shift_en;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] err_count;

  ccff_loader #(.DATA_W(8), .LEN_W(16)) dut (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .start      (start),
    .chain_len  (chain_len),
    .verify_en  (verify_en),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail),
    .shift_en   (shift_en),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_count  (err_count)
  );

  always #5 prog_clk = ~prog_clk;

  logic [7:0] chain = 8'h00;
  always @(posedge prog_clk) if (shift_en) chain <= {chain[6:0], ccff_head};
  assign ccff_tail = chain[7];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  bit sb[$];
  int tb_len, push_left;
  int cyc = 0, shifts, stalls, accepts, done_cnt, done_cyc, last_shift_cyc, start_cyc;
  bit ready_seen;
  logic [7:0] words [0:3];

  always @(negedge prog_clk) begin
    bit b;
    cyc++;
    if (shift_en) begin
      shifts++;
      last_shift_cyc = cyc;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        b = sb.pop_front();
        chk("head_bit", int'(ccff_head), int'(b));
      end
    end else if (busy) begin
      stalls++;
      chk("starve_head", int'(ccff_head), 0);
    end
    if (data_ready) ready_seen = 1'b1;
    if (data_valid && data_ready) begin
      accepts++;
      if (push_left == 0) push_left = tb_len;
      for (int i = 7; i >= 0; i--)
        if (push_left > 0) begin
          sb.push_back(data_in[i]);
          push_left--;
        end
    end
    if (start && !busy && !done) start_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic begin_run(input int len);
    sb.delete();
    tb_len = len;
    push_left = len;
    shifts = 0; stalls = 0; accepts = 0; done_cnt = 0;
    done_cyc = -1; last_shift_cyc = -1; start_cyc = -1;
    ready_seen = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge prog_clk);
      if (data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout_ready", 0, 1);
  endtask

  task automatic do_run(input string nm, input int len, input bit ven, input int nwords,
                        input int gap_at, input int gap_len, input bit poke,
                        input int exp_err, input int exp_stalls);
    bit ok;
    begin_run(len);
    chain_len = 16'(len);
    verify_en = ven;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      if (i == gap_at && gap_len > 0) begin
        data_valid = 1'b0;
        wait_ready(ok);
        if (poke) begin
          start = 1'b1;
          chain_len = 16'd3;
        end
        repeat (gap_len) begin
          @(posedge prog_clk); #1;
          start = 1'b0;
        end
      end
      data_in = words[i];
      data_valid = 1'b1;
      wait_ready(ok);
      @(posedge prog_clk); #1;
    end
    data_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge prog_clk); #2;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({nm, "_timeout_done"}, 0, 1);
    repeat (2) @(posedge prog_clk);
    #1;
    chk({nm, "_shifts"}, shifts, len * (ven ? 2 : 1));
    chk({nm, "_done_pulses"}, done_cnt, 1);
    if (len > 0) chk({nm, "_done_lat"}, done_cyc, last_shift_cyc + 1);
    else         chk({nm, "_done_lat"}, done_cyc, start_cyc + 1);
    chk({nm, "_error"}, int'(error), (exp_err != 0) ? 1 : 0);
    chk({nm, "_err_count"}, int'(err_count), exp_err);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_sb_left"}, sb.size(), 0);
    if (exp_stalls >= 0) chk({nm, "_stalls"}, stalls, exp_stalls);
    if (len == 0) chk({nm, "_ready_seen"}, int'(ready_seen), 0);
  endtask

  initial begin
    bit ok;
    pReset = 1'b0; start = 1'b0; chain_len = '0; verify_en = 1'b0;
    data_in = '0; data_valid = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("reset_outs", int'({data_ready, shift_en, ccff_head, busy, done, error}), 0);
    chk("reset_errcnt", int'(err_count), 0);
    pReset = 1'b1;
    repeat (2) @(posedge prog_clk);
    #1;

    // 12-bit chain, two words, continuous source, excess bits dropped
    words[0] = 8'hA5; words[1] = 8'h3C;
    do_run("basic12", 12, 1'b0, 2, -1, 0, 1'b0, 0, 1);
    chk("basic12_accepts", accepts, 2);

    // verify pass with identical data
    words[0] = 8'h5A; words[1] = 8'h5A;
    do_run("verify_ok", 8, 1'b1, 2, -1, 0, 1'b0, 0, 2);

    // verify pass with one flipped bit; error held after done
    words[0] = 8'h5A; words[1] = 8'h5B;
    do_run("verify_bad", 8, 1'b1, 2, -1, 0, 1'b0, 1, 2);
    repeat (3) @(posedge prog_clk);
    #1;
    chk("verify_bad_hold", int'(err_count), 1);

    // source starvation for 3 cycles between words
    words[0] = 8'hC3; words[1] = 8'h96;
    do_run("gap", 16, 1'b0, 2, 1, 3, 1'b0, 0, 4);

    // start pulsed while busy is ignored
    words[0] = 8'h81; words[1] = 8'h7E;
    do_run("poke", 16, 1'b0, 2, 1, 3, 1'b1, 0, 4);

    // empty chain
    do_run("len0", 0, 1'b0, 0, -1, 0, 1'b0, 0, 0);

    // reset in the middle of a pass
    begin_run(16);
    chain_len = 16'd16; verify_en = 1'b0;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    data_in = 8'hFF; data_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge prog_clk); #1;
      if (shifts == 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rst_mid_timeout", 0, 1);
    pReset = 1'b0;
    #1;
    chk("rst_mid_outs", int'({data_ready, shift_en, ccff_head, busy, done, error}), 0);
    data_valid = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    pReset = 1'b1;
    repeat (5) @(posedge prog_clk);
    #1;
    chk("rst_no_shift", shifts, 5);
    chk("rst_idle", int'(busy), 0);

    words[0] = 8'hA5; words[1] = 8'h3C;
    do_run("after_rst", 16, 1'b0, 2, -1, 0, 1'b0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
